// File: rtl/mmio_seg7_responder_if.sv
// Data-memory bus bundle between the core (master) and a memory-mapped
// responder (slave): read strobe, byte write enables, address, write data
// and registered read data.
interface mmio_seg7_responder_if;
  logic        rd;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output we, output addr, output wdata, input rdata);
  modport slave  (input rd, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/mmio_seg7_responder.sv
// Memory-mapped seven-segment display responder.
// DATA holds four hex digits, CTRL holds a per-digit blank mask and a scan
// enable, and STATUS exposes the digit currently being driven. A prescaler
// steps the digit index every REFRESH_DIV clocks, and a registered output
// stage drives the active-low segments and anodes.
module mmio_seg7_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int          REFRESH_DIV = 100000
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  mmio_seg7_responder_if.slave       bus,
  output logic [6:0]                 o_seg,
  output logic [3:0]                 o_an
);

  // 20 bits covers the largest legal divider (2^20 - 1 terminal count).
  localparam int PRSC_W = 20;

  typedef enum logic [1:0] {
    SEL_DATA   = 2'd0,
    SEL_CTRL   = 2'd1,
    SEL_STATUS = 2'd2,
    SEL_RSVD   = 2'd3
  } sel_e;

  logic [15:0]       r_data;
  logic [4:0]        r_ctrl;
  logic [PRSC_W-1:0] r_presc;
  logic [1:0]        r_idx;
  logic [31:0]       r_rdata;
  logic [6:0]        r_seg;
  logic [3:0]        r_an;

  logic              w_hit;
  sel_e              w_sel;
  logic              w_data_wr;
  logic              w_ctrl_wr;
  logic              w_en;
  logic              w_en_next;
  logic              w_wrap;
  logic [31:0]       w_rd_val;
  logic [3:0]        w_digit;
  logic              w_unused;

  assign w_hit     = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign w_sel     = sel_e'(bus.addr[3:2]);
  assign w_data_wr = w_hit && (w_sel == SEL_DATA);
  assign w_ctrl_wr = w_hit && (w_sel == SEL_CTRL) && bus.we[0];
  assign w_en      = r_ctrl[4];
  // The scan engine looks at the enable that will hold after this edge so the
  // index is already 0 in the first cycle after a disabling write.
  assign w_en_next = w_ctrl_wr ? bus.wdata[4] : w_en;
  assign w_wrap    = (r_presc == PRSC_W'(REFRESH_DIV - 1));
  assign w_digit   = r_data[{r_idx, 2'b00} +: 4];

  // Address bits [1:0] and the upper write-data half are deliberately ignored.
  assign w_unused  = &{1'b0, bus.addr[1:0], bus.wdata[31:16]};

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Read mux over the register window, sampled before any same-cycle write.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_rd_val unassigned (no latch).
    w_rd_val = '0;
    case (w_sel)
      SEL_DATA:   w_rd_val = {16'h0000, r_data};
      SEL_CTRL:   w_rd_val = {27'h0, r_ctrl};
      SEL_STATUS: w_rd_val = {30'h0, r_idx};
      default:    w_rd_val = '0;
    endcase
  end

  // Register writes: independent byte lanes for DATA, lane 0 only for CTRL.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: async reset clears all state at once, so an in-flight write never lands partially.
      r_data <= '0;
      r_ctrl <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (w_data_wr && bus.we[0]) r_data[7:0]  <= bus.wdata[7:0];
      if (w_data_wr && bus.we[1]) r_data[15:8] <= bus.wdata[15:8];
      if (w_ctrl_wr)              r_ctrl       <= bus.wdata[4:0];
    end
  end

  // Registered read data: load on rd (0 on a miss), hold otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (bus.rd) begin
      r_rdata <= w_hit ? w_rd_val : '0;
    end
  end

  // Scan engine: prescaler and digit index, held at 0 while disabled and
  // restarted from digit 0 on an enable rising edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (!w_en_next || !w_en) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_wrap) begin
      r_presc <= '0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + PRSC_W'(1);
    end
  end

  // Output stage: one cycle behind the index, DATA and CTRL it decodes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
    end else if (w_en) begin
      r_an  <= ~(4'b0001 << r_idx) | r_ctrl[3:0];
      r_seg <= hex7(w_digit);
    end else begin
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
    end
  end

  assign bus.rdata = r_rdata;
  assign o_seg     = r_seg;
  assign o_an      = r_an;

endmodule

// File: tb/tb_mmio_seg7_responder.sv
// Bench for mmio_seg7_responder: directed scenarios followed by random bus
// traffic. A reference model derives the digit index from the number of
// cycles spent enabled; each cycle's expected an/seg/rdata goes into a queue
// that an independent monitor drains after the clock edge.
module tb_mmio_seg7_responder;

  localparam int          DIV  = 4;
  localparam logic [31:0] BASE = 32'h0000_2000;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst;
  logic [6:0] seg;
  logic [3:0] an;

  mmio_seg7_responder_if bus ();

  mmio_seg7_responder #(
    .BASE_ADDR   (BASE),
    .REFRESH_DIV (DIV)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus),
    .o_seg (seg),
    .o_an  (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t exp_q[$];

  // Reference model state.
  logic [15:0] m_data;
  logic [4:0]  m_ctrl;
  int          m_t;      // cycles elapsed since scanning (re)started
  logic [31:0] m_rdata;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int model_idx();
    return m_ctrl[4] ? (m_t / DIV) % 4 : 0;
  endfunction

  task automatic model_reset();
    m_data  = '0;
    m_ctrl  = '0;
    m_t     = 0;
    m_rdata = '0;
  endtask

  // One bus cycle, called at a falling edge; returns at the next falling edge.
  task automatic drive(input logic rd, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int   idx;
    logic hit;
    int   sel;
    logic old_en;
    bus.rd = rd; bus.we = we; bus.addr = addr; bus.wdata = wd;

    idx    = model_idx();
    old_en = m_ctrl[4];
    e.an   = old_en ? (~(4'b0001 << idx) | m_ctrl[3:0]) : 4'hF;
    e.seg  = old_en ? hex_tab[(m_data >> (4 * idx)) & 16'hF] : 7'h7F;

    hit = (addr >> 4) == (BASE >> 4);
    sel = (addr >> 2) & 3;
    if (rd) begin
      if (!hit)          m_rdata = 0;
      else if (sel == 0) m_rdata = {16'h0, m_data};
      else if (sel == 1) m_rdata = {27'h0, m_ctrl};
      else if (sel == 2) m_rdata = idx;
      else               m_rdata = 0;
    end
    e.rdata = m_rdata;
    exp_q.push_back(e);

    if (hit && sel == 0 && we[0]) m_data[7:0]  = wd[7:0];
    if (hit && sel == 0 && we[1]) m_data[15:8] = wd[15:8];
    if (hit && sel == 1 && we[0]) m_ctrl       = wd[4:0];
    m_t = (m_ctrl[4] && old_en) ? m_t + 1 : 0;

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Monitor: every cycle the DUT presents an/seg/rdata, compare with the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("an",    {28'h0, an},  {28'h0, e.an});
        check("seg",   {25'h0, seg}, {25'h0, e.seg});
        check("rdata", bus.rdata,    e.rdata);
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1;
    bus.rd = 1'b0; bus.we = 4'h0; bus.addr = '0; bus.wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_an",    {28'h0, an},  32'hF);
    check("reset_seg",   {25'h0, seg}, 32'h7F);
    check("reset_rdata", bus.rdata,    32'h0);
    rst = 1'b0;

    // Scan DATA=0x1234 with all digits lit, 20 clocks (more than one full period).
    drive(1'b0, 4'hF, BASE + 32'h0, 32'hFFFF_1234);
    drive(1'b0, 4'h1, BASE + 32'h4, 32'h0000_0010);
    idle(20);

    // Byte-lane write to DATA[15:8] only, then read back.
    drive(1'b0, 4'b0010, BASE + 32'h0, 32'h0000_AB00);
    drive(1'b1, 4'h0,    BASE + 32'h0, 32'h0);
    idle(1);

    // Blank digits 0 and 2.
    drive(1'b0, 4'h1, BASE + 32'h4, 32'h0000_0015);
    idle(17);

    // STATUS on consecutive slots, reserved word, and an address past the window.
    drive(1'b0, 4'h1, BASE + 32'h4, 32'h0000_0010);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'h0, BASE + 32'h8, 32'h0);
      idle(DIV - 1);
    end
    drive(1'b1, 4'hF, BASE + 32'hC,  32'hFFFF_FFFF);
    drive(1'b1, 4'h0, BASE + 32'h10, 32'h0);
    drive(1'b1, 4'h0, BASE + 32'h4,  32'h0);
    idle(1);

    // Same-cycle read and write of DATA returns the old value.
    drive(1'b1, 4'hF, BASE + 32'h2, 32'h0000_5A5A);
    idle(3);

    // Disable mid-slot, then re-enable and watch digit 0 for a full slot.
    drive(1'b0, 4'h1, BASE + 32'h4, 32'h0);
    idle(3);
    drive(1'b0, 4'h1, BASE + 32'h4, 32'h0000_0010);
    idle(10);

    // Reset mid-scan with non-zero rdata: outputs clear without a clock edge.
    drive(1'b1, 4'h0, BASE + 32'h0, 32'h0);
    idle(2);
    #2 rst = 1'b1;
    #1;
    check("async_an",    {28'h0, an},  32'hF);
    check("async_seg",   {25'h0, seg}, 32'h7F);
    check("async_rdata", bus.rdata,    32'h0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(1'b1, 4'h0, BASE + 32'h0, 32'h0);
    drive(1'b1, 4'h0, BASE + 32'h4, 32'h0);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [3:0]  w;
      k = $urandom_range(0, 5);
      if (k < 4)       a = BASE + 32'(4 * k) + 32'($urandom_range(0, 3));
      else if (k == 4) a = BASE + 32'h10;
      else             a = $urandom;
      w = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      drive(1'($urandom_range(0, 1)), w, a, $urandom);
    end
    idle(2);

    // Bounded drain of any outstanding expectations.
    k = 0;
    while (exp_q.size() > 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
